// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
//
// Two-source vectored interrupt controller with a three-state entry sequence.
// On entry it pushes the return address, then asks the core to load the
// handler vector. On return it pops the stack. Source 0 (timer) has priority
// over source 1 (external) and may preempt a running source-1 handler.
//
// Parameters
//   VW          width of the PC, vector and stack-data buses
//
// Ports
//   clk         system clock, all state changes on its rising edge
//   reset       synchronous active-high reset
//   irq[1:0]    interrupt lines, irq[0] = timer, irq[1] = external
//   enable      global interrupt enable
//   mask[1:0]   per-source enable, 1 = source allowed
//   vec0, vec1  handler addresses for source 0 and source 1
//   pc_next     return address saved on entry
//   reti        one-cycle return-from-interrupt pulse from decode
//   push        stack push strobe (registered)
//   push_data   value to push
//   pop         stack pop strobe (registered)
//   int_req     PC-load request, one cycle wide (registered)
//   int_vec     PC value while int_req=1, holds its last value otherwise
//   pending     latched, not-yet-taken requests
//   in_service  sources whose handler is active
//   nest_err    sticky protocol-error flag, cleared only by reset
// ---------------------------------------------------------------------------
module interrupt_controller #(
  parameter int VW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    irq,
  input  logic          enable,
  input  logic [1:0]    mask,
  input  logic [VW-1:0] vec0,
  input  logic [VW-1:0] vec1,
  input  logic [VW-1:0] pc_next,
  input  logic          reti,
  output logic          push,
  output logic [VW-1:0] push_data,
  output logic          pop,
  output logic          int_req,
  output logic [VW-1:0] int_vec,
  output logic [1:0]    pending,
  output logic [1:0]    in_service,
  output logic          nest_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PUSH     = 2'd1;
  localparam logic [1:0] DISPATCH = 2'd2;

  logic [1:0] state;
  logic [1:0] irq_q;
  logic [1:0] armed;     // line has been seen low since reset
  logic       sel_q;     // source chosen at entry, used for the vector
  logic [1:0] rise;
  logic [1:0] elig;
  logic       sel;
  logic       take;
  logic [1:0] take_clr;

  always_comb begin
    rise = irq & ~irq_q & armed;
    // A source is blocked by any active handler of equal or higher priority,
    // so source 0 may interrupt a source-1 handler but never the reverse.
    elig[0] = pending[0] & mask[0] & enable & ~in_service[0];
    elig[1] = pending[1] & mask[1] & enable & (in_service == 2'b00);
    sel      = ~elig[0];
    // reti is served first; an eligible source waits one more cycle.
    take     = (state == IDLE) && !reti && (elig != 2'b00);
    take_clr = take ? (sel ? 2'b10 : 2'b01) : 2'b00;
  end

  // NOTE: every register here is assigned with <= so all of them see the
  // pre-edge values of each other; the FSM outputs are registered, not decoded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      irq_q      <= 2'b00;
      // A line held high through reset must drop before it can edge again,
      // so arming starts from the level sampled during reset.
      armed      <= ~irq;
      sel_q      <= 1'b0;
      pending    <= 2'b00;
      in_service <= 2'b00;
      nest_err   <= 1'b0;
      push       <= 1'b0;
      pop        <= 1'b0;
      int_req    <= 1'b0;
      push_data  <= '0;
      int_vec    <= '0;
    end else begin
      irq_q <= irq;
      armed <= armed | ~irq;
      push  <= 1'b0;
      pop   <= 1'b0;
      // A new edge in the same cycle as the take clear keeps the bit set.
      pending <= (pending & ~take_clr) | rise;

      case (state)
        IDLE: begin
          if (reti) begin
            if (in_service != 2'b00) begin
              pop <= 1'b1;
              // x & (x-1) drops the lowest set bit: the innermost handler.
              in_service <= in_service & (in_service - 2'd1);
            end else begin
              nest_err <= 1'b1;
            end
          end else if (take) begin
            state           <= PUSH;
            push            <= 1'b1;
            push_data       <= pc_next;
            in_service[sel] <= 1'b1;
            sel_q           <= sel;
          end
        end
        PUSH: begin
          state   <= DISPATCH;
          int_req <= 1'b1;
          int_vec <= sel_q ? vec1 : vec0;
          if (reti) nest_err <= 1'b1;
        end
        DISPATCH: begin
          state   <= IDLE;
          int_req <= 1'b0;
          if (reti) nest_err <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
//
// Directed scenarios followed by random stimulus, all compared each cycle
// against a transaction-level reference model: pending requests as a bit
// array, the active handlers as a LIFO of source numbers, and the entry
// sequence as a phase count.
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

  localparam int VW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    irq;
  logic          enable;
  logic [1:0]    mask;
  logic [VW-1:0] vec0, vec1, pc_next;
  logic          reti;
  logic          push, pop, int_req, nest_err;
  logic [VW-1:0] push_data, int_vec;
  logic [1:0]    pending, in_service;

  interrupt_controller #(.VW(VW)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .enable     (enable),
    .mask       (mask),
    .vec0       (vec0),
    .vec1       (vec1),
    .pc_next    (pc_next),
    .reti       (reti),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .pending    (pending),
    .in_service (in_service),
    .nest_err   (nest_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [1:0]    m_prev, m_armed, m_pend;
  int            m_stack[$];     // front = innermost active handler
  int            m_phase;        // 0 idle, 1 pushing, 2 dispatching
  int            m_src;
  logic          m_err;
  logic          e_push, e_pop, e_req;
  logic [VW-1:0] e_pdata, e_vec;

  function automatic logic [1:0] m_isrv();
    logic [1:0] r = 2'b00;
    foreach (m_stack[k]) r[m_stack[k]] = 1'b1;
    return r;
  endfunction

  function automatic bit m_elig(int i);
    if (!(m_pend[i] && mask[i] && enable)) return 1'b0;
    foreach (m_stack[k]) if (m_stack[k] <= i) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic [1:0] rise;
    bit el0, el1;
    if (reset) begin
      m_armed = ~irq;
      m_prev  = 2'b00;
      m_pend  = 2'b00;
      m_stack.delete();
      m_phase = 0;
      m_src   = 0;
      m_err   = 1'b0;
      e_push  = 1'b0; e_pop = 1'b0; e_req = 1'b0;
      e_pdata = '0;   e_vec = '0;
      return;
    end
    rise   = irq & ~m_prev & m_armed;
    el0    = m_elig(0);
    el1    = m_elig(1);
    e_push = 1'b0;
    e_pop  = 1'b0;
    e_req  = 1'b0;
    if (m_phase == 0) begin
      if (reti) begin
        if (m_stack.size() > 0) begin
          void'(m_stack.pop_front());
          e_pop = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end else if (el0 || el1) begin
        m_src = el0 ? 0 : 1;
        m_stack.push_front(m_src);
        m_pend[m_src] = 1'b0;
        e_push  = 1'b1;
        e_pdata = pc_next;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (reti) m_err = 1'b1;
      e_req   = 1'b1;
      e_vec   = (m_src == 1) ? vec1 : vec0;
      m_phase = 2;
    end else begin
      if (reti) m_err = 1'b1;
      m_phase = 0;
    end
    m_pend  = m_pend | rise;
    m_prev  = irq;
    m_armed = m_armed | ~irq;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic check_all();
    check("push",       32'(push),       32'(e_push));
    check("pop",        32'(pop),        32'(e_pop));
    check("int_req",    32'(int_req),    32'(e_req));
    check("push_data",  32'(push_data),  32'(e_pdata));
    check("int_vec",    32'(int_vec),    32'(e_vec));
    check("pending",    32'(pending),    32'(m_pend));
    check("in_service", 32'(in_service), 32'(m_isrv()));
    check("nest_err",   32'(nest_err),   32'(m_err));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; irq = 2'b00; enable = 1'b0; mask = 2'b00;
    vec0 = '0; vec1 = '0; pc_next = '0; reti = 1'b0;
    step(); step();
    check("reset_int_vec", 32'(int_vec), 32'h0);
    reset = 1'b0;
    step();

    // Single interrupt on source 0
    enable = 1'b1; mask = 2'b11; pc_next = 10'h025; vec0 = 10'h300; vec1 = 10'h1A0;
    irq = 2'b01; step();
    check("single_pending", 32'(pending), 32'h1);
    irq = 2'b00; step();
    check("single_push", 32'(push), 32'h1);
    check("single_push_data", 32'(push_data), 32'h025);
    step();
    check("single_int_req", 32'(int_req), 32'h1);
    check("single_int_vec", 32'(int_vec), 32'h300);
    check("single_in_service", 32'(in_service), 32'h1);
    step();
    check("single_req_width", 32'(int_req), 32'h0);
    check("single_vec_hold", 32'(int_vec), 32'h300);
    reti = 1'b1; step();
    reti = 1'b0; step();

    // Priority: both sources at the same edge
    irq = 2'b11; step();
    irq = 2'b00; step(); step(); step();
    check("prio_first_in_service", 32'(in_service), 32'h1);
    reti = 1'b1; step();
    check("prio_pop", 32'(pop), 32'h1);
    check("prio_pop_clear", 32'(in_service), 32'h0);
    reti = 1'b0; step(); step();
    check("prio_vec1", 32'(int_vec), 32'h1A0);
    step();
    reti = 1'b1; step();
    reti = 1'b0; step();

    // Preemption of a source-1 handler by source 0
    pc_next = 10'h111;
    irq = 2'b10; step();
    irq = 2'b00; step(); step(); step();
    check("preempt_outer", 32'(in_service), 32'h2);
    pc_next = 10'h222;
    irq = 2'b01; step();
    irq = 2'b00; step();
    check("preempt_push_data", 32'(push_data), 32'h222);
    step();
    check("preempt_vec0", 32'(int_vec), 32'h300);
    check("preempt_nested", 32'(in_service), 32'h3);
    step();
    reti = 1'b1; step();
    check("preempt_pop0", 32'(in_service), 32'h2);
    step();
    check("preempt_pop1", 32'(in_service), 32'h0);
    reti = 1'b0; step();

    // Masking holds the request without dispatch
    mask = 2'b10;
    irq = 2'b01; step();
    irq = 2'b00; step(); step();
    check("mask_pending", 32'(pending), 32'h1);
    check("mask_no_push", 32'(push), 32'h0);
    mask = 2'b11; step(); step();
    check("mask_release_req", 32'(int_req), 32'h1);
    step();
    reti = 1'b1; step();
    reti = 1'b0; step();

    // Protocol error and its clearing by reset
    reti = 1'b1; step();
    check("err_set", 32'(nest_err), 32'h1);
    check("err_no_pop", 32'(pop), 32'h0);
    reti = 1'b0; step();
    reset = 1'b1; step();
    check("err_cleared", 32'(nest_err), 32'h0);
    reset = 1'b0; step();

    // Reset in the middle of an entry sequence
    irq = 2'b01; step();
    irq = 2'b00; step();
    reset = 1'b1; step();
    check("mid_reset_req", 32'(int_req), 32'h0);
    check("mid_reset_isrv", 32'(in_service), 32'h0);
    reset = 1'b0; step(); step();

    // Line held high through reset is not an edge
    irq = 2'b01; reset = 1'b1; step();
    reset = 1'b0; step(); step();
    check("held_no_edge", 32'(pending), 32'h0);
    irq = 2'b00; step();
    irq = 2'b01; step();
    check("held_then_edge", 32'(pending), 32'h1);
    irq = 2'b00;

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      irq     = 2'($urandom_range(0, 3));
      reti    = ($urandom_range(0, 5) == 0);
      enable  = ($urandom_range(0, 7) != 0);
      mask    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      reset   = ($urandom_range(0, 59) == 0);
      pc_next = VW'($urandom);
      vec0    = VW'($urandom);
      vec1    = VW'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter: VW, default 10, width of PC, vector and stack-data buses.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 irq  input  2  interrupt lines; irq[0] = timer (highest priority), irq[1] = external.
REQ-005 enable  input  1  global interrupt enable.
REQ-006 mask  input  2  per-source enable; mask[i]=1 allows source i.
REQ-007 vec0, vec1  input  VW each  handler addresses for source 0 and source 1.
REQ-008 pc_next  input  VW  return address to save on entry.
REQ-009 reti  input  1  one-cycle pulse from decode: return from interrupt.
REQ-010 push  output  1  stack push strobe.
REQ-011 push_data  output  VW  value to push.
REQ-012 pop  output  1  stack pop strobe.
REQ-013 int_req  output  1  PC-load request.
REQ-014 int_vec  output  VW  PC value while int_req=1.
REQ-015 pending  output  2  latched, not-yet-taken requests.
REQ-016 in_service  output  2  sources whose handler is active.
REQ-017 nest_err  output  1  sticky protocol-error flag.

Function
REQ-018 Each irq[i] is registered into irq_q[i]; pending[i] sets on a clock edge where irq[i]=1 and irq_q[i]=0 (rising edge only).
REQ-019 Source i is eligible when pending[i], mask[i] and enable are all 1, and in_service has no bit set at an index <= i.
REQ-020 When both sources are eligible, source 0 is selected.
REQ-021 The FSM has three states: IDLE, PUSH and DISPATCH; push, pop and int_req are registered outputs.
REQ-022 In IDLE with reti=0 and a source eligible, the next state is PUSH: push=1, push_data=pc_next sampled at that edge, pending[sel] cleared, in_service[sel] set.
REQ-023 PUSH always proceeds to DISPATCH after one cycle: int_req=1, int_vec=vec of the selected source, push=0.
REQ-024 DISPATCH always returns to IDLE after one cycle; int_req is exactly one cycle wide.
REQ-025 With int_req=0, int_vec holds its last value, which is 0 after reset.
REQ-026 Latency: with pending set at edge E0 and the source eligible, push is high for the cycle E1-E2 and int_req for the cycle E2-E3.
REQ-027 reti in IDLE with in_service nonzero asserts pop for one cycle and clears the lowest-index set bit of in_service.
REQ-028 reti in IDLE with in_service=0 sets nest_err; no pop is issued.
REQ-029 reti in PUSH or DISPATCH is ignored and sets nest_err.
REQ-030 reti and an eligible source together in IDLE: reti is served first; the interrupt is taken next cycle if still eligible.
REQ-031 A new rising edge on irq[i] in the same cycle pending[i] is cleared leaves pending[i]=1 (set wins).
REQ-032 A rising edge on irq[i] while in_service[i]=1 latches pending[i]; it is taken only after that handler's reti.
REQ-033 enable and mask gate eligibility only; pending still latches while they are 0.
REQ-034 Source 0 may preempt an active source 1 handler, giving a nesting depth of at most 2.
REQ-035 nest_err clears only on reset.

Reset
REQ-036 A reset at any edge, including mid-PUSH or mid-DISPATCH, forces state=IDLE.
REQ-037 Reset clears irq_q, pending, in_service, nest_err, push, pop, int_req, push_data and int_vec to 0, with no partial push or dispatch issued.
REQ-038 An irq held high through reset is not seen as an edge until it has been sampled low again.

Verification
REQ-039 Single interrupt: enable=1, mask=11, pc_next=0x025, vec0=0x300, pulse irq[0] -> push=1 with push_data=0x025 one cycle, then int_req=1 with int_vec=0x300 one cycle, in_service=01.
REQ-040 Priority: irq=11 at the same edge -> source 0 served first; source 1 is served after the reti pop (pop=1, in_service 01->00), then int_vec=vec1.
REQ-041 Preemption: source 1 in service (in_service=10), then irq[0] pulse -> second push and dispatch to vec0, in_service=11; two retis -> pops clear bit 0, then bit 1.
REQ-042 Masking: mask=10, irq[0] pulse -> pending=01, no push; then mask=11 -> dispatch to vec0 two cycles later.
REQ-043 Errors: reti with in_service=00 -> nest_err=1 and pop=0; a later reset -> nest_err=0.
REQ-044 Reset mid-operation: reset asserted during PUSH -> the next cycle shows int_req=0, in_service=00, pending=00, state IDLE.
